// File: rtl/reg_bus_arbiter_pkg.sv
`default_nettype none
// led_bus_pkg: widths, arbiter state encoding and request-field type for the LED register bus.
// rev 1.0
package led_bus_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/reg_bus_arbiter_rr_pick.sv
`default_nettype none
// rr_pick: combinational winner picker, round-robin after last_i or fixed lowest-index priority.
// rev 1.0
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  input  logic             fixed_i,
  output logic [N-1:0]     win_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             valid_o
);

  always_comb begin
    logic [IDX_W-1:0] k;
    win_o     = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    k         = '0;
    // Scan starts one past the last owner so the previous winner is checked last.
    for (int i = 0; i < N; i++) begin
      k = fixed_i ? IDX_W'(i) : IDX_W'((int'(last_i) + 1 + i) % N);
      if (!valid_o && req_i[k]) begin
        valid_o   = 1'b1;
        win_o[k]  = 1'b1;
        win_idx_o = k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
`default_nettype none
// reg_bus_arbiter: shares the LED register bus between NUM_REQ masters, one access per grant, with lock bursts.
// rev 1.0
module reg_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = led_bus_pkg::ADDR_W,
  parameter int DATA_W    = led_bus_pkg::DATA_W,
  parameter int FIXED_PRI = 0,
  parameter int LOCK_MAX  = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        lock_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [ADDR_W-1:0]         bus_addr_o,
  output logic [DATA_W-1:0]         bus_wdata_o,
  output logic                      bus_w_en_o,
  output logic                      bus_r_en_o,
  input  logic [DATA_W-1:0]         bus_rdata_i,
  output logic                      busy_o
);
  import led_bus_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(LOCK_MAX - 1);

  arb_state_t          state_q;
  logic [IDX_W-1:0]    owner_q, last_owner_q;
  logic [CNT_W-1:0]    lock_cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q, bus_addr_q;
  logic [DATA_W-1:0]   wdata_q, bus_wdata_q, rdata_q;
  logic [NUM_REQ-1:0]  gnt_q, ack_q;
  logic                bus_w_en_q, bus_r_en_q;

  logic [NUM_REQ-1:0]  win;
  logic [IDX_W-1:0]    win_idx, sel_idx;
  logic                win_vld, other_pend, forced_off, keep;
  logic [NUM_REQ-1:0]  owner_oh;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (req_i),
    .last_i    (last_owner_q),
    .fixed_i   (FIXED_PRI != 0),
    .win_o     (win),
    .win_idx_o (win_idx),
    .valid_o   (win_vld)
  );

  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign other_pend = |(req_i & ~owner_oh);
  // The burst limit only bites while someone else is waiting; alone, the counter just saturates.
  assign forced_off = other_pend && (lock_cnt_q >= CNT_TOP);
  assign keep       = lock_i[owner_q] && req_i[owner_q] && !forced_off;
  assign sel_idx    = (state_q == IDLE) ? win_idx : owner_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      lock_cnt_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      gnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_w_en_q   <= 1'b0;
      bus_r_en_q   <= 1'b0;
    end else begin
      ack_q      <= '0;
      bus_w_en_q <= 1'b0;
      bus_r_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            we_q    <= we_i[sel_idx];
            addr_q  <= addr_i[sel_idx*ADDR_W +: ADDR_W];
            wdata_q <= wdata_i[sel_idx*DATA_W +: DATA_W];
            owner_q <= win_idx;
            gnt_q   <= win;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          bus_addr_q  <= addr_q;
          bus_wdata_q <= wdata_q;
          bus_w_en_q  <= we_q;
          bus_r_en_q  <= ~we_q;
          state_q     <= CAPTURE;
        end
        CAPTURE: begin
          ack_q <= owner_oh;
          if (!we_q) rdata_q <= bus_rdata_i;
          if (keep) begin
            we_q    <= we_i[sel_idx];
            addr_q  <= addr_i[sel_idx*ADDR_W +: ADDR_W];
            wdata_q <= wdata_i[sel_idx*DATA_W +: DATA_W];
            if (lock_cnt_q != CNT_TOP) lock_cnt_q <= lock_cnt_q + 1'b1;
            state_q <= ACCESS;
          end else begin
            gnt_q        <= '0;
            last_owner_q <= owner_q;
            lock_cnt_q   <= '0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_w_en_o  = bus_w_en_q;
  assign bus_r_en_o  = bus_r_en_q;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
`default_nettype none
// tb_reg_bus_arbiter: directed self-checking bench for reg_bus_arbiter with a combinational register-file model.
// rev 1.0
module tb_reg_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req, lock, we;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  gnt, ack;
  logic [7:0]  rdata, bus_wdata, bus_rdata;
  logic [2:0]  bus_addr;
  logic        bus_w_en, bus_r_en, busy;

  int   total = 0;
  int   bad   = 0;
  logic overlap_seen = 1'b0;
  logic gnt_bad      = 1'b0;
  logic [7:0] mem [8];

  int m0, m1, at_m1, first_c, last_c;
  logic started, dropped;

  always #5 clk = ~clk;

  assign bus_rdata = mem[bus_addr];

  always @(negedge clk) begin
    if (bus_w_en && bus_r_en) overlap_seen <= 1'b1;
    if (!$onehot0(gnt))       gnt_bad      <= 1'b1;
  end

  reg_bus_arbiter dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .req_i       (req),
    .lock_i      (lock),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .ack_o       (ack),
    .rdata_o     (rdata),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_w_en_o  (bus_w_en),
    .bus_r_en_o  (bus_r_en),
    .bus_rdata_i (bus_rdata),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(gnt != 2'b00), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    reset_n = 1'b0;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    tick();
    tick();
    chk("rst_gnt",   32'(gnt), 32'd0);
    chk("rst_ack",   32'(ack), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_bus",   32'({bus_addr, bus_wdata, bus_w_en, bus_r_en}), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: M0 write addr 3 data A5
    req = 2'b01; we = 2'b01; addr = {3'd0, 3'd3}; wdata = {8'h00, 8'hA5};
    tick();
    chk("t1_gnt",  32'(gnt), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_nostrobe", 32'(bus_w_en), 32'd0);
    req = 2'b00; addr = '0; wdata = '0;
    tick();
    chk("t1_wen",   32'(bus_w_en), 32'd1);
    chk("t1_ren",   32'(bus_r_en), 32'd0);
    chk("t1_addr",  32'(bus_addr), 32'd3);
    chk("t1_wdata", 32'(bus_wdata), 32'hA5);
    chk("t1_noack", 32'(ack), 32'd0);
    tick();
    chk("t1_wen_off", 32'(bus_w_en), 32'd0);
    chk("t1_ack",     32'(ack), 32'h1);
    chk("t1_gnt_off", 32'(gnt), 32'd0);
    tick();
    chk("t1_ack_off", 32'(ack), 32'd0);
    chk("t1_idle",    32'(busy), 32'd0);

    // 2: M1 read addr 5 returning 3C
    mem[5] = 8'h3C;
    req = 2'b10; we = 2'b00; addr = {3'd5, 3'd0};
    tick();
    chk("t2_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    chk("t2_ren",  32'(bus_r_en), 32'd1);
    chk("t2_wen",  32'(bus_w_en), 32'd0);
    chk("t2_addr", 32'(bus_addr), 32'd5);
    tick();
    chk("t2_ack",   32'(ack), 32'h2);
    chk("t2_rdata", 32'(rdata), 32'h3C);
    mem[5] = 8'h00;
    tick();
    tick();
    chk("t2_hold", 32'(rdata), 32'h3C);

    // 3: simultaneous unlocked requests alternate
    req = 2'b11; we = 2'b11; addr = {3'd2, 3'd1}; wdata = {8'h22, 8'h11};
    for (int k = 0; k < 4; k++) begin
      logic [1:0] eg;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt("t3_wait");
      chk("t3_gnt", 32'(gnt), 32'(eg));
      if (k == 3) req = 2'b00;
      tick();
      chk("t3_addr", 32'(bus_addr), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("t3_ack", 32'(ack), 32'(eg));
    end
    tick();
    tick();
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: M0 locked burst of 20, M1 arrives after access 2
    req = 2'b01; lock = 2'b01; we = 2'b11; addr = {3'd6, 3'd4}; wdata = {8'h66, 8'h44};
    m0 = 0; m1 = 0; at_m1 = -1;
    for (int c = 0; c < 300 && m0 < 20; c++) begin
      tick();
      if (gnt[1] && at_m1 < 0) begin
        at_m1 = m0;
        req[1] = 1'b0;
      end
      if (ack[0]) begin
        m0++;
        if (m0 == 2) req[1] = 1'b1;
        if (m0 == 19) begin
          req[0]  = 1'b0;
          lock[0] = 1'b0;
        end
      end
      if (ack[1]) m1++;
    end
    tick();
    tick();
    chk("t4_release_at", 32'(at_m1), 32'd8);
    chk("t4_m0_total",   32'(m0), 32'd20);
    chk("t4_m1_total",   32'(m1), 32'd1);
    chk("t4_idle",       32'(gnt), 32'd0);

    // 5: M0 locked burst alone, 2-cycle period, grant held
    req = 2'b01; lock = 2'b01;
    m0 = 0; first_c = -1; last_c = -1; started = 1'b0; dropped = 1'b0;
    for (int c = 0; c < 300 && m0 < 20; c++) begin
      tick();
      if (ack[0]) begin
        m0++;
        if (m0 == 1)  first_c = c;
        if (m0 == 20) last_c = c;
        if (m0 == 19) begin
          req  = 2'b00;
          lock = 2'b00;
        end
      end
      if (started && m0 < 20 && gnt !== 2'b01) dropped = 1'b1;
      if (gnt == 2'b01) started = 1'b1;
    end
    chk("t5_count",   32'(m0), 32'd20);
    chk("t5_span",    32'(last_c - first_c), 32'd38);
    chk("t5_gnt_held", 32'(dropped), 32'd0);
    tick();
    tick();

    // 6: reset in the ACCESS cycle
    req = 2'b01; we = 2'b01; addr = {3'd0, 3'd7}; wdata = {8'h00, 8'h5A};
    tick();
    chk("t6_gnt", 32'(gnt), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_gnt",   32'(gnt), 32'd0);
    chk("t6_rst_busy",  32'(busy), 32'd0);
    chk("t6_rst_rdata", 32'(rdata), 32'd0);
    req = 2'b00;
    tick();
    chk("t6_no_strobe", 32'({bus_w_en, bus_r_en}), 32'd0);
    tick();
    chk("t6_no_ack", 32'(ack), 32'd0);
    reset_n = 1'b1;
    tick();
    mem[5] = 8'h77;
    req = 2'b11; we = 2'b00; addr = {3'd2, 3'd5};
    tick();
    chk("t6_gnt_m0_first", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    chk("t6_ren", 32'(bus_r_en), 32'd1);
    tick();
    chk("t6_ack",   32'(ack), 32'h1);
    chk("t6_rdata", 32'(rdata), 32'h77);

    chk("no_strobe_overlap", 32'(overlap_seen), 32'd0);
    chk("gnt_onehot",        32'(gnt_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
